// File: rtl/bn_scheduler.sv
// rtl/bn_scheduler.sv - channel sequencer feeding BN2d with per-channel weight/bias
module bn_scheduler #(
    parameter int CH_MAX  = 64,
    parameter int CW      = $clog2(CH_MAX),
    parameter int LEN_W   = 16,
    parameter int MAX_OUT = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cfg_we,
    input  logic [CW-1:0]    i_cfg_addr,
    input  logic [15:0]      i_cfg_weight,
    input  logic [15:0]      i_cfg_bias,
    input  logic             i_start,
    input  logic [CW:0]      i_num_ch,
    input  logic [LEN_W-1:0] i_ch_len,
    input  logic             i_in_valid,
    input  logic [15:0]      i_in_data,
    output logic             o_in_ready,
    output logic [15:0]      o_bn_data,
    output logic [15:0]      o_bn_weight,
    output logic [15:0]      o_bn_bias,
    output logic             o_bn_issue,
    input  logic [15:0]      i_bn_result,
    input  logic             i_bn_finish,
    output logic             o_out_valid,
    output logic [15:0]      o_out_data,
    output logic [CW-1:0]    o_out_ch,
    output logic             o_out_last,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_err
);

    localparam int OW = $clog2(MAX_OUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [15:0]      r_w_tab [CH_MAX];
    logic [15:0]      r_b_tab [CH_MAX];

    logic [CW:0]      r_num_ch;
    logic [LEN_W-1:0] r_ch_len;
    logic [CW-1:0]    r_ch;
    logic [LEN_W-1:0] r_issue_cnt;
    logic [LEN_W-1:0] r_res_cnt;
    logic [OW-1:0]    r_outstanding;

    logic [15:0]      r_bn_data;
    logic [15:0]      r_bn_weight;
    logic [15:0]      r_bn_bias;
    logic             r_bn_issue;
    logic             r_out_valid;
    logic [15:0]      r_out_data;
    logic [CW-1:0]    r_out_ch;
    logic             r_out_last;
    logic             r_err;

    logic             w_start_ok;
    logic             w_xfer;
    logic             w_fin_ok;
    logic             w_fin_drop;
    logic             w_last_ch;
    logic             w_drained;
    logic [OW:0]      w_inflight;

    // The pending issue is counted too, so the limit holds before the counter catches up
    assign w_inflight = {1'b0, r_outstanding} + (OW+1)'(r_bn_issue);
    assign w_fin_ok   = i_bn_finish && (r_outstanding != '0);
    assign w_fin_drop = i_bn_finish && (r_outstanding == '0);
    assign w_last_ch  = (({1'b0, r_ch} + (CW+1)'(1)) == r_num_ch);
    assign w_drained  = (r_outstanding == '0) && !r_bn_issue;

    assign o_bn_data   = r_bn_data;
    assign o_bn_weight = r_bn_weight;
    assign o_bn_bias   = r_bn_bias;
    assign o_bn_issue  = r_bn_issue;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_ch    = r_out_ch;
    assign o_out_last  = r_out_last;
    assign o_err       = r_err;

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode plus Moore-style handshake and status outputs
    always_comb begin
        w_state_nxt = r_state;
        o_in_ready  = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        w_start_ok  = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start && (i_num_ch != '0) && (i_ch_len != '0)) begin
                    w_start_ok  = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                o_busy      = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                o_busy     = 1'b1;
                o_in_ready = (w_inflight < (OW+1)'(MAX_OUT));
                w_xfer     = i_in_valid && o_in_ready;
                if (w_xfer && ((r_issue_cnt + LEN_W'(1)) == r_ch_len))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (w_drained)
                    w_state_nxt = w_last_ch ? S_DONE : S_SETUP;
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Parameter table has no reset so its contents survive resets and layers
    always_ff @(posedge i_clk) begin
        if ((r_state == S_IDLE) && i_cfg_we) begin
            r_w_tab[i_cfg_addr] <= i_cfg_weight;
            r_b_tab[i_cfg_addr] <= i_cfg_bias;
        end
    end

    // Layer configuration and channel index
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_num_ch <= '0;
            r_ch_len <= '0;
            r_ch     <= '0;
        end else if (w_start_ok) begin
            r_num_ch <= i_num_ch;
            r_ch_len <= i_ch_len;
            r_ch     <= '0;
        end else if ((r_state == S_DRAIN) && w_drained && !w_last_ch) begin
            r_ch <= r_ch + CW'(1);
        end
    end

    // Channel parameters change only in SETUP, after the previous channel drained
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_bn_weight <= '0;
            r_bn_bias   <= '0;
        end else if (r_state == S_SETUP) begin
            r_bn_weight <= r_w_tab[r_ch];
            r_bn_bias   <= r_b_tab[r_ch];
        end
    end

    // Issue path: one registered element per accepted transfer
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_bn_issue  <= 1'b0;
            r_bn_data   <= '0;
            r_issue_cnt <= '0;
        end else begin
            r_bn_issue <= w_xfer;
            if (w_xfer)
                r_bn_data <= i_in_data;
            if (r_state == S_SETUP)
                r_issue_cnt <= '0;
            else if (w_xfer)
                r_issue_cnt <= r_issue_cnt + LEN_W'(1);
        end
    end

    // Elements issued to BN2d whose finish has not yet been seen
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_outstanding <= '0;
        end else begin
            case ({r_bn_issue, w_fin_ok})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Result stream: counted finishes pass straight through, tagged with channel and last
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_last  <= 1'b0;
            r_res_cnt   <= '0;
        end else begin
            r_out_valid <= w_fin_ok;
            r_out_last  <= w_fin_ok && ((r_res_cnt + LEN_W'(1)) == r_ch_len);
            if (w_fin_ok) begin
                r_out_data <= i_bn_result;
                r_out_ch   <= r_ch;
            end
            if (r_state == S_SETUP)
                r_res_cnt <= '0;
            else if (w_fin_ok)
                r_res_cnt <= r_res_cnt + LEN_W'(1);
        end
    end

    // Sticky error for a finish with nothing outstanding; a new error beats the clear
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)          r_err <= 1'b0;
        else if (w_fin_drop) r_err <= 1'b1;
        else if (w_start_ok) r_err <= 1'b0;
    end

endmodule

// File: tb/tb_bn_scheduler.sv
// tb/tb_bn_scheduler.sv - scoreboard bench for bn_scheduler with a BN2d latency model
`timescale 1ns/1ps
module tb_bn_scheduler;

    localparam int CW = 6;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_cfg_we = 1'b0;
    logic [CW-1:0] i_cfg_addr = '0;
    logic [15:0]   i_cfg_weight = '0;
    logic [15:0]   i_cfg_bias = '0;
    logic          i_start = 1'b0;
    logic [CW:0]   i_num_ch = '0;
    logic [15:0]   i_ch_len = '0;
    logic          i_in_valid = 1'b0;
    logic [15:0]   i_in_data = '0;
    logic          o_in_ready;
    logic [15:0]   o_bn_data, o_bn_weight, o_bn_bias;
    logic          o_bn_issue;
    logic [15:0]   i_bn_result = '0;
    logic          i_bn_finish = 1'b0;
    logic          o_out_valid;
    logic [15:0]   o_out_data;
    logic [CW-1:0] o_out_ch;
    logic          o_out_last;
    logic          o_busy, o_done, o_err;

    bn_scheduler dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cfg_we(i_cfg_we), .i_cfg_addr(i_cfg_addr),
        .i_cfg_weight(i_cfg_weight), .i_cfg_bias(i_cfg_bias),
        .i_start(i_start), .i_num_ch(i_num_ch), .i_ch_len(i_ch_len),
        .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
        .o_bn_data(o_bn_data), .o_bn_weight(o_bn_weight), .o_bn_bias(o_bn_bias),
        .o_bn_issue(o_bn_issue), .i_bn_result(i_bn_result), .i_bn_finish(i_bn_finish),
        .o_out_valid(o_out_valid), .o_out_data(o_out_data), .o_out_ch(o_out_ch),
        .o_out_last(o_out_last), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [15:0]   data;
        logic [CW-1:0] ch;
        logic          last;
    } exp_t;

    typedef struct {
        logic [15:0] r;
        int          due;
    } bn_t;

    exp_t        sbq[$];
    bn_t         mq[$];
    int          errors = 0;
    int          checks = 0;
    int          ncyc = 0;
    int          bn_lat = 2;
    int          done_cnt = 0;
    int          last_cnt = 0;
    int          first_issue = -1;
    int          last_issue = -1;
    int          max_inflight = 0;
    bit          inject_stray = 1'b0;
    bit          busy_seen = 1'b0;
    logic [15:0] tw [4];
    logic [15:0] tbias [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] bnf(input logic [15:0] d, input logic [15:0] w, input logic [15:0] b);
        return (d ^ w) + b;
    endfunction

    // BN2d model: fixed latency, in-order, result depends on data and the parameters seen at issue
    always @(negedge i_clk) begin
        bn_t e;
        ncyc++;
        i_bn_finish = 1'b0;
        if (mq.size() > 0 && mq[0].due <= ncyc) begin
            i_bn_finish = 1'b1;
            i_bn_result = mq[0].r;
            void'(mq.pop_front());
        end else if (inject_stray) begin
            i_bn_finish  = 1'b1;
            i_bn_result  = 16'hDEAD;
            inject_stray = 1'b0;
        end
        if (o_bn_issue) begin
            e.r   = bnf(o_bn_data, o_bn_weight, o_bn_bias);
            e.due = ncyc + bn_lat;
            mq.push_back(e);
            if (first_issue < 0) first_issue = ncyc;
            last_issue = ncyc;
        end
        if (mq.size() > max_inflight) max_inflight = mq.size();
    end

    // Monitor: pop and compare every presented result, count done pulses
    always @(negedge i_clk) begin
        exp_t e;
        if (o_busy) busy_seen = 1'b1;
        if (o_done) begin
            done_cnt++;
            chk("busy_low_at_done", 32'(o_busy), 32'(0));
        end
        if (o_out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid actual=data %0h ch %0d required=no output", o_out_data, o_out_ch);
            end else begin
                e = sbq.pop_front();
                chk("out_data", 32'(o_out_data), 32'(e.data));
                chk("out_ch", 32'(o_out_ch), 32'(e.ch));
                chk("out_last", 32'(o_out_last), 32'(e.last));
                if (o_out_last) last_cnt++;
            end
        end
    end

    // One layer: start, optional config write while busy, feed elements, wait for done.
    // abort_at >= 0 asserts reset just after that element's transfer edge.
    task automatic run_layer(input int nch, input int len, input int lat, input bit poke, input int abort_at);
        int          idx;
        int          n;
        int          d0;
        logic [15:0] d;
        exp_t        x;
        idx    = 0;
        bn_lat = lat;
        d0     = done_cnt;
        i_num_ch = (CW+1)'(nch);
        i_ch_len = 16'(len);
        i_start  = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        if (poke) begin
            i_cfg_we     = 1'b1;
            i_cfg_addr   = '0;
            i_cfg_weight = 16'h7777;
            i_cfg_bias   = 16'h1111;
            @(negedge i_clk);
            @(negedge i_clk);
            i_cfg_we = 1'b0;
        end
        for (int c = 0; c < nch; c++) begin
            for (int e = 0; e < len; e++) begin
                d = 16'(16'h0100 * c + 16'h0013 * e + 16'h0A05);
                i_in_valid = 1'b1;
                i_in_data  = d;
                n = 0;
                while (!o_in_ready && n < 2000) begin
                    @(negedge i_clk);
                    n++;
                end
                if (n >= 2000) begin
                    checks++;
                    errors++;
                    $display("FAIL in_ready_timeout actual=0 required=1");
                    i_in_valid = 1'b0;
                    return;
                end
                if (idx == abort_at) begin
                    @(posedge i_clk);
                    #1 i_rst = 1'b0;
                    #1;
                    chk("rst_in_ready", 32'(o_in_ready), 32'(0));
                    chk("rst_busy", 32'(o_busy), 32'(0));
                    chk("rst_bn_issue", 32'(o_bn_issue), 32'(0));
                    chk("rst_bn_data", 32'(o_bn_data), 32'(0));
                    chk("rst_bn_weight", 32'(o_bn_weight), 32'(0));
                    chk("rst_bn_bias", 32'(o_bn_bias), 32'(0));
                    chk("rst_out_data", 32'(o_out_data), 32'(0));
                    chk("rst_out_valid", 32'(o_out_valid), 32'(0));
                    i_in_valid = 1'b0;
                    @(negedge i_clk);
                    @(negedge i_clk);
                    i_rst = 1'b1;
                    @(negedge i_clk);
                    return;
                end
                x.data = bnf(d, tw[c], tbias[c]);
                x.ch   = CW'(c);
                x.last = (e == len - 1);
                sbq.push_back(x);
                @(negedge i_clk);
                idx++;
            end
        end
        i_in_valid = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(negedge i_clk);
            n++;
        end
        repeat (3) @(negedge i_clk);
        chk("done_pulses", 32'(done_cnt - d0), 32'(1));
        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        int l0;
        tw    = '{16'd2540, 16'h1234, 16'hF00D, 16'h0042};
        tbias = '{16'd8422, 16'h0F0F, 16'h8001, 16'h5A5A};

        repeat (3) @(negedge i_clk);
        chk("reset_in_ready", 32'(o_in_ready), 32'(0));
        chk("reset_busy", 32'(o_busy), 32'(0));
        chk("reset_done", 32'(o_done), 32'(0));
        chk("reset_err", 32'(o_err), 32'(0));
        chk("reset_out_valid", 32'(o_out_valid), 32'(0));
        chk("reset_bn_issue", 32'(o_bn_issue), 32'(0));
        chk("reset_bn_weight", 32'(o_bn_weight), 32'(0));
        chk("reset_out_data", 32'(o_out_data), 32'(0));
        i_rst = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 4; i++) begin
            i_cfg_we     = 1'b1;
            i_cfg_addr   = CW'(i);
            i_cfg_weight = tw[i];
            i_cfg_bias   = tbias[i];
            @(negedge i_clk);
        end
        i_cfg_we = 1'b0;

        // single channel, consecutive issues
        first_issue = -1;
        run_layer(1, 5, 2, 1'b0, -1);
        chk("t1_issue_span", 32'(last_issue - first_issue), 32'(4));
        chk("t1_bn_weight", 32'(o_bn_weight), 32'(2540));
        chk("t1_bn_bias", 32'(o_bn_bias), 32'(8422));

        // three channels with distinct parameters
        l0 = last_cnt;
        run_layer(3, 4, 3, 1'b0, -1);
        chk("t2_last_count", 32'(last_cnt - l0), 32'(3));
        chk("t2_bn_weight_final", 32'(o_bn_weight), 32'(tw[2]));

        // back-pressure with long BN2d latency
        max_inflight = 0;
        run_layer(1, 12, 20, 1'b0, -1);
        chk("t3_max_outstanding", 32'(max_inflight), 32'(8));

        // zero-length and zero-channel starts are ignored
        d0 = done_cnt;
        busy_seen = 1'b0;
        i_num_ch = 7'd1;
        i_ch_len = 16'd0;
        i_start  = 1'b1;
        @(negedge i_clk);
        i_num_ch = 7'd0;
        i_ch_len = 16'd5;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("t4_busy_never", 32'(busy_seen), 32'(0));
        chk("t4_no_done", 32'(done_cnt - d0), 32'(0));

        // config write while busy is ignored; readback run uses original entry 0
        run_layer(1, 3, 2, 1'b1, -1);
        run_layer(1, 3, 2, 1'b0, -1);
        chk("t5_weight_kept", 32'(o_bn_weight), 32'(tw[0]));
        chk("t5_bias_kept", 32'(o_bn_bias), 32'(tbias[0]));

        // stray finish in IDLE sets err, next valid start clears it
        inject_stray = 1'b1;
        repeat (4) @(negedge i_clk);
        chk("t6_err_set", 32'(o_err), 32'(1));
        run_layer(1, 2, 2, 1'b0, -1);
        chk("t6_err_cleared", 32'(o_err), 32'(0));

        // reset at the first transfer of channel 1, then a clean rerun
        run_layer(2, 4, 3, 1'b0, 4);
        chk("t7_sbq_after_reset", 32'(sbq.size()), 32'(0));
        chk("t7_err_after_reset", 32'(o_err), 32'(0));
        l0 = last_cnt;
        run_layer(2, 4, 3, 1'b0, -1);
        chk("t7_rerun_lasts", 32'(last_cnt - l0), 32'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bn_scheduler.md
# bn_scheduler

Channel sequencer for the BN2d batch-norm datapath. Holds a per-channel weight/bias table and streams `num_ch` channels of `ch_len` signed 16-bit activations through BN2d. Per channel it presents that channel's weight/bias, issues data with back-pressure, collects `finish_flag` results, and drains the datapath before switching channel. It sits between the activation buffer and BN2d in the layer pipeline.

## Interface
- `CH_MAX`, 64, number of parameter-table entries; `CW = clog2(CH_MAX)`
- `LEN_W`, 16, width of the per-channel element count
- `MAX_OUT`, 8, maximum issued-but-unfinished elements in BN2d
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `cfg_we`  in  1  parameter-table write strobe
- `cfg_addr`  in  CW  table index
- `cfg_weight`  in  16  signed weight
- `cfg_bias`  in  16  signed bias
- `start`  in  1  begin a layer; sampled in IDLE only
- `num_ch`  in  CW+1  channels to process, 1..CH_MAX; sampled with `start`
- `ch_len`  in  LEN_W  elements per channel, >=1; sampled with `start`
- `in_valid`  in  1  activation available
- `in_data`  in  16  signed activation
- `in_ready`  out  1  scheduler accepts `in_data`
- `bn_data`  out  16  to BN2d `data`
- `bn_weight`, `bn_bias`  out  16 each  to BN2d `weight` and `bias`
- `bn_issue`  out  1  `bn_data` is a new element this cycle
- `bn_result`  in  16  from BN2d `result`
- `bn_finish`  in  1  from BN2d `finish_flag`
- `out_valid`, `out_data` (16), `out_ch` (CW), `out_last` (1)  out  result stream; `out_last` marks the last result of a channel
- `busy`  out  1  high outside IDLE
- `done`  out  1  one-cycle pulse at layer end
- `err`  out  1  sticky: `bn_finish` arrived with nothing outstanding; cleared by `start`

## Operation
- Parameter table: written only in IDLE. `cfg_we` outside IDLE is ignored. The table is not cleared by reset and keeps its contents.
- FSM states:
  - IDLE: when `start` is high and `num_ch` and `ch_len` are both nonzero, latch `num_ch`/`ch_len`, set `ch=0`, clear `err`, go to SETUP. A `start` with either value zero is ignored.
  - SETUP (1 cycle): load `bn_weight`/`bn_bias` from `table[ch]`, clear the issue and result counters, go to RUN.
  - RUN: `in_ready = (outstanding < MAX_OUT)`. A transfer occurs when `in_valid && in_ready`. The transfer that makes the issue count equal `ch_len` moves the FSM to DRAIN.
  - DRAIN: `in_ready=0`. Wait until `outstanding==0` with no issue pending. Then go to DONE if `ch==num_ch-1`, otherwise `ch++` and go to SETUP.
  - DONE: pulse `done`, return to IDLE.
- `outstanding` counter:
  - +1 on `bn_issue`, -1 on a counted `bn_finish`; unchanged when both occur in the same cycle.
  - A `bn_finish` with `outstanding==0` is dropped: no `out_valid`, `err` set.
- Results:
  - Each counted `bn_finish` registers `bn_result` to `out_data` with `out_ch=ch`.
  - `out_last=1` when the per-channel result count reaches `ch_len`.
  - Results are never reordered.
- `bn_weight`/`bn_bias` stay constant from SETUP until the next SETUP, so every element in flight sees its own channel's parameters.
- No arithmetic on data: `out_data` equals `bn_result` bit-for-bit.

## Timing
- Reset values (async assert): state IDLE; `in_ready`, `bn_issue`, `out_valid`, `out_last`, `busy`, `done`, `err` all 0; `bn_data`, `bn_weight`, `bn_bias`, `out_data`, `out_ch` all 0; counters 0.
- `start` sampled at edge k: SETUP in cycle k+1, first `in_ready=1` in cycle k+2.
- Input transfer at edge t: `bn_data`/`bn_issue` valid in cycle t+1, one cycle wide.
- `bn_finish` at edge u: `out_valid` in cycle u+1, one cycle wide.
- Channel switch overhead: DRAIN exit, then 1 SETUP cycle, then RUN.
- Reset mid-operation: immediate abort to IDLE. In-flight BN2d results arriving after reset are counted as `err` (outstanding is 0).
- `done` is high exactly one cycle. `busy` falls in the same cycle `done` is high.

## Test plan
- Single channel: table[0]=(2540, 8422); `num_ch=1`, `ch_len=5`; `in_valid` held high; BN2d model latency 2 -> `bn_weight=2540`, `bn_bias=8422`; 5 `bn_issue` pulses on consecutive cycles; 5 `out_valid` with `out_ch=0`, `out_last` on the 5th; single `done`.
- Three channels with distinct table entries, `ch_len=4` -> `bn_weight`/`bn_bias` change only after all 4 results of the previous channel; `out_ch` sequence 0,0,0,0,1…,2; `out_last` three times.
- Back-pressure: BN2d latency 20, `MAX_OUT=8` -> `in_ready` drops after 8 issues and resumes on the first `bn_finish`; `outstanding` never exceeds 8.
- Zero-length rejection: `start` with `ch_len=0` -> `busy` stays 0, no `done`. Then `cfg_we` during RUN -> table unchanged (verified by a readback run).
- Stray finish: `bn_finish` in IDLE -> `err=1`, no `out_valid`; the next valid `start` clears `err`.
- Reset during RUN of channel 1 -> all outputs 0 asynchronously; a restarted run uses the retained table values and completes normally.
